// File: rtl/lsu_stbuf_pkg.sv
// Types and constants shared by the store buffer queue and its forwarding network.
// Also holds the SECDED encoder used on the drain path.
package lsu_stbuf_pkg;

    localparam int STBUF_DEPTH = 4;
    localparam int ADDR_BITS   = 16;
    localparam int DATA_WIDTH  = 32;
    localparam int ECC_WIDTH   = 7;
    localparam int BYTES       = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        DRAINED = 2'd2
    } stbuf_state_e;

    typedef struct packed {
        logic [ADDR_BITS-1:0]  addr;
        logic [DATA_WIDTH-1:0] data;
        logic [BYTES-1:0]      byteen;
        logic                  in_pic;
    } stbuf_entry_t;

    // Hamming SECDED: data bits fill the non-power-of-two codeword positions in order;
    // a set data bit toggles exactly the check bits named by its position. Top bit is overall parity.
    function automatic logic [ECC_WIDTH-1:0] rvecc_encode(input logic [DATA_WIDTH-1:0] din);
        logic [DATA_WIDTH-1:0] d;
        logic [ECC_WIDTH-2:0]  chk;
        d   = din;
        chk = '0;
        for (int p = 1; p < DATA_WIDTH + ECC_WIDTH; p++) begin
            if ((p & (p - 1)) != 0) begin
                chk = chk ^ (d[0] ? (ECC_WIDTH-1)'(p) : '0);
                d   = d >> 1;
            end
        end
        return {^{din, chk}, chk};
    endfunction

endpackage

// File: rtl/lsu_stbuf_fwd.sv
// Per-byte store-to-load forward merge for one load word address across all buffer entries.
// Latency: combinational (caller flops the result into dc3).
// Backpressure: none; a pure lookup that never stalls.
module lsu_stbuf_fwd
    import lsu_stbuf_pkg::*;
#(
    parameter int DEPTH = STBUF_DEPTH
) (
    input  logic [DEPTH-1:0][ADDR_BITS-3:0]  ent_waddr,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
    input  logic [DEPTH-1:0][BYTES-1:0]      ent_byteen,
    input  logic [DEPTH-1:0]                 ent_vld,
    input  logic [$clog2(DEPTH)-1:0]         wr_ptr,
    input  logic                             enq_vld,
    input  logic [ADDR_BITS-3:0]             enq_waddr,
    input  logic [DATA_WIDTH-1:0]            enq_data,
    input  logic [BYTES-1:0]                 enq_byteen,
    input  logic [ADDR_BITS-3:0]             ld_waddr,
    output logic [BYTES-1:0]                 fwd_byteen,
    output logic [DATA_WIDTH-1:0]            fwd_data
);

    localparam int PW = $clog2(DEPTH);

    logic [BYTES-1:0]      hit_be    [DEPTH+1];
    logic [DATA_WIDTH-1:0] cand_data [DEPTH+1];

    // Candidates ordered oldest (slot at wr_ptr) to youngest, same-cycle enqueue last.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            hit_be[k]    = (ent_vld[wr_ptr + PW'(k)] && (ent_waddr[wr_ptr + PW'(k)] == ld_waddr))
                           ? ent_byteen[wr_ptr + PW'(k)] : '0;
            cand_data[k] = ent_data[wr_ptr + PW'(k)];
        end
        hit_be[DEPTH]    = (enq_vld && (enq_waddr == ld_waddr)) ? enq_byteen : '0;
        cand_data[DEPTH] = enq_data;
    end

    // Later (younger) candidates overwrite earlier ones byte by byte.
    always_comb begin
        fwd_byteen = '0;
        fwd_data   = '0;
        for (int k = 0; k <= DEPTH; k++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (hit_be[k][b]) begin
                    fwd_byteen[b]      = 1'b1;
                    fwd_data[8*b +: 8] = cand_data[k][8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/lsu_stbuf_queue.sv
// Committed-store buffer: circular queue draining its head to DCCM/PIC, forwarding pending bytes to loads.
// Latency: enqueue visible at head next cycle; forward lookup dc2 -> dc3 in 1 cycle; drain port combinational.
// Backpressure: head holds until lsu_stbuf_commit_any; enqueue while full is dropped and sets stbuf_ovf.
module lsu_stbuf_queue
    import lsu_stbuf_pkg::*;
#(
    parameter int DEPTH = STBUF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stbuf_wr_en,
    input  logic [ADDR_BITS-1:0]  stbuf_wr_addr,
    input  logic [DATA_WIDTH-1:0] stbuf_wr_data,
    input  logic [BYTES-1:0]      stbuf_wr_byteen,
    input  logic                  stbuf_wr_in_pic,
    input  logic                  lsu_stbuf_commit_any,
    input  logic                  ld_valid_dc2,
    input  logic [ADDR_BITS-1:0]  ld_addr_lo_dc2,
    input  logic [ADDR_BITS-1:0]  ld_addr_hi_dc2,
    output logic                  stbuf_reqvld_any,
    output logic [ADDR_BITS-1:0]  stbuf_addr_any,
    output logic [DATA_WIDTH-1:0] stbuf_data_any,
    output logic [ECC_WIDTH-1:0]  stbuf_ecc_any,
    output logic                  stbuf_addr_in_pic_any,
    output logic [DATA_WIDTH-1:0] stbuf_fwddata_lo_dc3,
    output logic [DATA_WIDTH-1:0] stbuf_fwddata_hi_dc3,
    output logic [BYTES-1:0]      stbuf_fwdbyteen_lo_dc3,
    output logic [BYTES-1:0]      stbuf_fwdbyteen_hi_dc3,
    output logic                  stbuf_full,
    output logic                  stbuf_empty,
    output logic                  stbuf_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    stbuf_state_e                    state [DEPTH];
    stbuf_entry_t [DEPTH-1:0]        ent;
    logic [PW-1:0]                   wr_ptr;
    logic [PW-1:0]                   rd_ptr;
    logic [CW-1:0]                   cnt;
    logic                            enq;
    logic                            deq;
    logic                            retire;
    logic [DEPTH-1:0]                ent_vld;
    logic [DEPTH-1:0][ADDR_BITS-3:0]  ent_waddr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data;
    logic [DEPTH-1:0][BYTES-1:0]      ent_byteen;
    logic [BYTES-1:0]                fwd_be_lo;
    logic [BYTES-1:0]                fwd_be_hi;
    logic [DATA_WIDTH-1:0]           fwd_dat_lo;
    logic [DATA_WIDTH-1:0]           fwd_dat_hi;
    logic                            unused_addr_lsbs;

    assign unused_addr_lsbs = ^{stbuf_wr_addr[1:0], ld_addr_lo_dc2[1:0], ld_addr_hi_dc2[1:0]};

    assign stbuf_full  = (cnt == CW'(DEPTH));
    assign stbuf_empty = (cnt == '0);
    assign enq         = stbuf_wr_en & ~stbuf_full;

    assign stbuf_reqvld_any      = (state[rd_ptr] == PEND);
    assign deq                   = lsu_stbuf_commit_any & stbuf_reqvld_any;
    assign stbuf_addr_any        = ent[rd_ptr].addr;
    assign stbuf_data_any        = ent[rd_ptr].data;
    assign stbuf_addr_in_pic_any = ent[rd_ptr].in_pic;
    assign stbuf_ecc_any         = rvecc_encode(stbuf_data_any);

    // DRAINED lasts exactly one cycle, so at most one entry retires per cycle.
    always_comb begin
        retire     = 1'b0;
        ent_vld    = '0;
        ent_waddr  = '0;
        ent_data   = '0;
        ent_byteen = '0;
        for (int k = 0; k < DEPTH; k++) begin
            ent_vld[k]    = (state[k] != IDLE);
            retire        = retire | (state[k] == DRAINED);
            ent_waddr[k]  = ent[k].addr[ADDR_BITS-1:2];
            ent_data[k]   = ent[k].data;
            ent_byteen[k] = ent[k].byteen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) state[k] <= IDLE;
            ent       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            stbuf_ovf <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (state[k] == DRAINED) state[k] <= IDLE;
            end
            if (deq) begin
                state[rd_ptr] <= DRAINED;
                rd_ptr        <= rd_ptr + PW'(1);
            end
            if (enq) begin
                state[wr_ptr] <= PEND;
                ent[wr_ptr]   <= '{addr:   {stbuf_wr_addr[ADDR_BITS-1:2], 2'b00},
                                   data:   stbuf_wr_data,
                                   byteen: stbuf_wr_byteen,
                                   in_pic: stbuf_wr_in_pic};
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (stbuf_wr_en && stbuf_full) stbuf_ovf <= 1'b1;
            cnt <= cnt + CW'(enq) - CW'(retire);
        end
    end

    lsu_stbuf_fwd #(.DEPTH(DEPTH)) u_fwd_lo (
        .ent_waddr  (ent_waddr),
        .ent_data   (ent_data),
        .ent_byteen (ent_byteen),
        .ent_vld    (ent_vld),
        .wr_ptr     (wr_ptr),
        .enq_vld    (enq),
        .enq_waddr  (stbuf_wr_addr[ADDR_BITS-1:2]),
        .enq_data   (stbuf_wr_data),
        .enq_byteen (stbuf_wr_byteen),
        .ld_waddr   (ld_addr_lo_dc2[ADDR_BITS-1:2]),
        .fwd_byteen (fwd_be_lo),
        .fwd_data   (fwd_dat_lo)
    );

    lsu_stbuf_fwd #(.DEPTH(DEPTH)) u_fwd_hi (
        .ent_waddr  (ent_waddr),
        .ent_data   (ent_data),
        .ent_byteen (ent_byteen),
        .ent_vld    (ent_vld),
        .wr_ptr     (wr_ptr),
        .enq_vld    (enq),
        .enq_waddr  (stbuf_wr_addr[ADDR_BITS-1:2]),
        .enq_data   (stbuf_wr_data),
        .enq_byteen (stbuf_wr_byteen),
        .ld_waddr   (ld_addr_hi_dc2[ADDR_BITS-1:2]),
        .fwd_byteen (fwd_be_hi),
        .fwd_data   (fwd_dat_hi)
    );

    always_ff @(posedge clk) begin
        if (rst || !ld_valid_dc2) begin
            stbuf_fwdbyteen_lo_dc3 <= '0;
            stbuf_fwdbyteen_hi_dc3 <= '0;
            stbuf_fwddata_lo_dc3   <= '0;
            stbuf_fwddata_hi_dc3   <= '0;
        end else begin
            stbuf_fwdbyteen_lo_dc3 <= fwd_be_lo;
            stbuf_fwdbyteen_hi_dc3 <= fwd_be_hi;
            stbuf_fwddata_lo_dc3   <= fwd_dat_lo;
            stbuf_fwddata_hi_dc3   <= fwd_dat_hi;
        end
    end

endmodule

// File: tb/tb_lsu_stbuf_queue.sv
// Randomized and directed stimulus for lsu_stbuf_queue against a queue-based store buffer model.
module tb_lsu_stbuf_queue;

    logic        clk;
    logic        rst;
    logic        stbuf_wr_en;
    logic [15:0] stbuf_wr_addr;
    logic [31:0] stbuf_wr_data;
    logic [3:0]  stbuf_wr_byteen;
    logic        stbuf_wr_in_pic;
    logic        lsu_stbuf_commit_any;
    logic        ld_valid_dc2;
    logic [15:0] ld_addr_lo_dc2;
    logic [15:0] ld_addr_hi_dc2;
    logic        stbuf_reqvld_any;
    logic [15:0] stbuf_addr_any;
    logic [31:0] stbuf_data_any;
    logic [6:0]  stbuf_ecc_any;
    logic        stbuf_addr_in_pic_any;
    logic [31:0] stbuf_fwddata_lo_dc3;
    logic [31:0] stbuf_fwddata_hi_dc3;
    logic [3:0]  stbuf_fwdbyteen_lo_dc3;
    logic [3:0]  stbuf_fwdbyteen_hi_dc3;
    logic        stbuf_full;
    logic        stbuf_empty;
    logic        stbuf_ovf;

    lsu_stbuf_queue dut (
        .clk                    (clk),
        .rst                    (rst),
        .stbuf_wr_en            (stbuf_wr_en),
        .stbuf_wr_addr          (stbuf_wr_addr),
        .stbuf_wr_data          (stbuf_wr_data),
        .stbuf_wr_byteen        (stbuf_wr_byteen),
        .stbuf_wr_in_pic        (stbuf_wr_in_pic),
        .lsu_stbuf_commit_any   (lsu_stbuf_commit_any),
        .ld_valid_dc2           (ld_valid_dc2),
        .ld_addr_lo_dc2         (ld_addr_lo_dc2),
        .ld_addr_hi_dc2         (ld_addr_hi_dc2),
        .stbuf_reqvld_any       (stbuf_reqvld_any),
        .stbuf_addr_any         (stbuf_addr_any),
        .stbuf_data_any         (stbuf_data_any),
        .stbuf_ecc_any          (stbuf_ecc_any),
        .stbuf_addr_in_pic_any  (stbuf_addr_in_pic_any),
        .stbuf_fwddata_lo_dc3   (stbuf_fwddata_lo_dc3),
        .stbuf_fwddata_hi_dc3   (stbuf_fwddata_hi_dc3),
        .stbuf_fwdbyteen_lo_dc3 (stbuf_fwdbyteen_lo_dc3),
        .stbuf_fwdbyteen_hi_dc3 (stbuf_fwdbyteen_hi_dc3),
        .stbuf_full             (stbuf_full),
        .stbuf_empty            (stbuf_empty),
        .stbuf_ovf              (stbuf_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        pic;
    } mst_t;

    // Model: pending stores oldest-first, plus the one just committed (still visible for a cycle).
    mst_t q[$];
    mst_t drained;
    int   drained_n;
    int   m_ovf;
    logic [3:0]  exp_be_lo;
    logic [3:0]  exp_be_hi;
    logic [31:0] exp_d_lo;
    logic [31:0] exp_d_hi;

    int n_tests;
    int n_fail;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] ecc_model(input logic [31:0] d);
        int pos[32];
        int n;
        logic [6:0] e;
        n = 0;
        for (int p = 3; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[n] = p;
                n++;
            end
        end
        e = '0;
        for (int j = 0; j < 6; j++)
            for (int i = 0; i < 32; i++)
                if (((pos[i] >> j) & 1) == 1) e[j] = e[j] ^ d[i];
        e[6] = ^{d, e[5:0]};
        return e;
    endfunction

    // For each byte, search from the youngest store backwards; first match wins.
    function automatic void fwd_model(input logic [15:0] la, input int enq_ok, input mst_t enq,
                                      output logic [3:0] be, output logic [31:0] d);
        mst_t c[$];
        if (drained_n != 0) c.push_back(drained);
        foreach (q[i]) c.push_back(q[i]);
        if (enq_ok != 0) c.push_back(enq);
        be = '0;
        d  = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = c.size() - 1; i >= 0; i--) begin
                if (c[i].addr[15:2] == la[15:2] && c[i].be[b]) begin
                    be[b]      = 1'b1;
                    d[8*b +: 8] = c[i].data[8*b +: 8];
                    break;
                end
            end
        end
    endfunction

    // One clock cycle: entered and left at a negedge; drives inputs, advances model, checks outputs.
    task automatic step(input logic r, input logic we, input logic [15:0] wa, input logic [31:0] wd,
                        input logic [3:0] wb, input logic wp, input logic cm,
                        input logic lv, input logic [15:0] la, input logic [15:0] ha);
        int   occ;
        int   enq_ok;
        mst_t e;
        occ    = q.size() + drained_n;
        enq_ok = (!r && we && occ < 4) ? 1 : 0;
        e.addr = wa & 16'hFFFC;
        e.data = wd;
        e.be   = wb;
        e.pic  = wp;
        rst = r; stbuf_wr_en = we; stbuf_wr_addr = wa; stbuf_wr_data = wd;
        stbuf_wr_byteen = wb; stbuf_wr_in_pic = wp; lsu_stbuf_commit_any = cm;
        ld_valid_dc2 = lv; ld_addr_lo_dc2 = la; ld_addr_hi_dc2 = ha;
        if (r || !lv) begin
            exp_be_lo = '0; exp_be_hi = '0; exp_d_lo = '0; exp_d_hi = '0;
        end else begin
            fwd_model(la, enq_ok, e, exp_be_lo, exp_d_lo);
            fwd_model(ha, enq_ok, e, exp_be_hi, exp_d_hi);
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            drained_n = 0;
            m_ovf     = 0;
        end else begin
            drained_n = 0;
            if (cm && q.size() > 0) begin
                drained   = q.pop_front();
                drained_n = 1;
            end
            if (we && occ >= 4) m_ovf = 1;
            if (enq_ok != 0) q.push_back(e);
        end
        @(negedge clk);
        occ = q.size() + drained_n;
        check_eq("reqvld", 64'(stbuf_reqvld_any), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("head_addr", 64'(stbuf_addr_any), 64'(q[0].addr));
            check_eq("head_data", 64'(stbuf_data_any), 64'(q[0].data));
            check_eq("head_pic", 64'(stbuf_addr_in_pic_any), 64'(q[0].pic));
            check_eq("head_ecc", 64'(stbuf_ecc_any), 64'(ecc_model(q[0].data)));
        end
        check_eq("full", 64'(stbuf_full), 64'(occ == 4));
        check_eq("empty", 64'(stbuf_empty), 64'(occ == 0));
        check_eq("ovf", 64'(stbuf_ovf), 64'(m_ovf != 0));
        check_eq("fwd_be_lo", 64'(stbuf_fwdbyteen_lo_dc3), 64'(exp_be_lo));
        check_eq("fwd_be_hi", 64'(stbuf_fwdbyteen_hi_dc3), 64'(exp_be_hi));
        check_eq("fwd_d_lo", 64'(stbuf_fwddata_lo_dc3), 64'(exp_d_lo));
        check_eq("fwd_d_hi", 64'(stbuf_fwddata_hi_dc3), 64'(exp_d_hi));
    endtask

    task automatic wr(input logic [15:0] wa, input logic [31:0] wd, input logic [3:0] wb);
        step(1'b0, 1'b1, wa, wd, wb, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic idle(input logic cm);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, cm, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic lookup(input logic [15:0] la, input logic [15:0] ha);
        step(1'b0, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, la, ha);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rl;
        logic [15:0] rh;
        n_tests = 0; n_fail = 0;
        drained_n = 0; m_ovf = 0;
        rst = 1'b1; stbuf_wr_en = 1'b0; stbuf_wr_addr = '0; stbuf_wr_data = '0;
        stbuf_wr_byteen = '0; stbuf_wr_in_pic = 1'b0; lsu_stbuf_commit_any = 1'b0;
        ld_valid_dc2 = 1'b0; ld_addr_lo_dc2 = '0; ld_addr_hi_dc2 = '0;
        @(negedge clk);
        do_reset();
        do_reset();
        check_eq("rst_addr", 64'(stbuf_addr_any), 64'h0);
        check_eq("rst_data", 64'(stbuf_data_any), 64'h0);
        check_eq("rst_ecc", 64'(stbuf_ecc_any), 64'h0);
        check_eq("rst_empty", 64'(stbuf_empty), 64'h1);

        // Single store becomes head.
        wr(16'h1000, 32'hDEADBEEF, 4'hF);
        check_eq("t1_reqvld", 64'(stbuf_reqvld_any), 64'h1);
        check_eq("t1_addr", 64'(stbuf_addr_any), 64'h1000);
        check_eq("t1_data", 64'(stbuf_data_any), 64'hDEADBEEF);
        check_eq("t1_empty", 64'(stbuf_empty), 64'h0);

        // Fill, overflow, then drain one: full drops two cycles after the commit.
        wr(16'h1004, 32'h11111111, 4'hF);
        wr(16'h1008, 32'h22222222, 4'hF);
        wr(16'h100C, 32'h33333333, 4'hF);
        wr(16'h1010, 32'h44444444, 4'hF);
        check_eq("t2_full", 64'(stbuf_full), 64'h1);
        check_eq("t2_ovf", 64'(stbuf_ovf), 64'h1);
        idle(1'b1);
        check_eq("t2_full_t1", 64'(stbuf_full), 64'h1);
        idle(1'b0);
        check_eq("t2_full_t2", 64'(stbuf_full), 64'h0);

        // Youngest store wins per byte.
        do_reset();
        wr(16'h2000, 32'h1234AA11, 4'h3);
        wr(16'h2000, 32'h5678BB22, 4'h1);
        lookup(16'h2000, 16'h2004);
        check_eq("t3_be", 64'(stbuf_fwdbyteen_lo_dc3), 64'h3);
        check_eq("t3_data", 64'(stbuf_fwddata_lo_dc3[15:0]), 64'hAA22);

        // Drained entry stays visible for exactly one cycle.
        do_reset();
        wr(16'h4000, 32'h0BADF00D, 4'hF);
        idle(1'b1);
        lookup(16'h4000, 16'h4004);
        check_eq("t4_be_t1", 64'(stbuf_fwdbyteen_lo_dc3), 64'hF);
        lookup(16'h4000, 16'h4004);
        check_eq("t4_be_t2", 64'(stbuf_fwdbyteen_lo_dc3), 64'h0);

        // Same-cycle enqueue bypass on lo, pending entry on hi.
        wr(16'h3004, 32'h11223344, 4'hC);
        step(1'b0, 1'b1, 16'h3000, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, 1'b1, 16'h3000, 16'h3004);
        check_eq("t5_d_lo", 64'(stbuf_fwddata_lo_dc3), 64'hCAFEF00D);
        check_eq("t5_be_hi", 64'(stbuf_fwdbyteen_hi_dc3), 64'hC);
        check_eq("t5_d_hi", 64'(stbuf_fwddata_hi_dc3), 64'h11220000);

        // Reset with stores pending and overflow set.
        wr(16'h3008, 32'h55555555, 4'hF);
        wr(16'h300C, 32'h66666666, 4'hF);
        wr(16'h3010, 32'h77777777, 4'hF);
        idle(1'b1);
        idle(1'b0);
        check_eq("t6_ovf_pre", 64'(stbuf_ovf), 64'h1);
        step(1'b1, 1'b0, 16'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b1, 16'h3004, 16'h3008);
        check_eq("t6_reqvld", 64'(stbuf_reqvld_any), 64'h0);
        check_eq("t6_empty", 64'(stbuf_empty), 64'h1);
        check_eq("t6_ovf", 64'(stbuf_ovf), 64'h0);
        check_eq("t6_fwd", 64'(stbuf_fwdbyteen_lo_dc3), 64'h0);

        // Random traffic over a small address window to provoke hits and full conditions.
        for (int i = 0; i < 3000; i++) begin
            ra = 16'h2000 + 16'($urandom_range(0, 15));
            rl = 16'h2000 + 16'($urandom_range(0, 15));
            rh = ($urandom_range(0, 1) == 1) ? rl + 16'h4 : 16'h2000 + 16'($urandom_range(0, 15));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 1) == 1), ra, $urandom,
                 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 3) != 0), rl, rh);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
